// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: op codes,
// sequencer states and flag bit positions.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'd0,
        S_WAIT_B  = 2'd1,
        S_WAIT_OP = 2'd2,
        S_SHOW    = 2'd3
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;

endpackage

// File: rtl/alu_input_sequencer_btn_edge_sync.sv
// Button synchroniser with single-cycle rising-edge pulse.
// A held level produces exactly one pulse.
module btn_edge_sync #(
    parameter int NB_SYNC = 2
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [NB_SYNC-1:0] sync_q;
    logic               prev_q;

    // Shift the raw pin through the sync chain and keep last level
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NB_SYNC-2:0], i_async};
            prev_q <= sync_q[NB_SYNC-1];
        end
    end

    assign o_rise = sync_q[NB_SYNC-1] & ~prev_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Ordered A -> B -> OP operand loader in front of the ALU.
// Result and flags are captured when the op code is loaded.
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_SYNC = 2
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [2:0]         i_btn,
    input  logic [NB_DATA-1:0] i_sw_data,
    input  logic               i_valid,
    output logic [NB_DATA-1:0] o_result,
    output logic [3:0]         o_flags,
    output logic [1:0]         o_state,
    output logic               o_done,
    output logic               o_err
);

    localparam int M = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SH_LIM = NB_DATA'(NB_DATA);

    localparam logic [NB_OP-1:0] C_ADD = NB_OP'(OP_ADD);
    localparam logic [NB_OP-1:0] C_SUB = NB_OP'(OP_SUB);
    localparam logic [NB_OP-1:0] C_AND = NB_OP'(OP_AND);
    localparam logic [NB_OP-1:0] C_OR  = NB_OP'(OP_OR);
    localparam logic [NB_OP-1:0] C_XOR = NB_OP'(OP_XOR);
    localparam logic [NB_OP-1:0] C_NOR = NB_OP'(OP_NOR);
    localparam logic [NB_OP-1:0] C_SRL = NB_OP'(OP_SRL);
    localparam logic [NB_OP-1:0] C_SRA = NB_OP'(OP_SRA);

    logic [2:0]         rise;
    logic [2:0]         pulse;
    state_t             state_q, state_d;
    logic               ld_a, ld_b, ld_op;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q, alu_op;
    logic [NB_DATA-1:0] result_q, alu_res;
    logic signed [NB_DATA-1:0] sra_v;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, alu_err, alu_c, alu_v;

    for (genvar g = 0; g < 3; g++) begin : g_btn
        btn_edge_sync #(.NB_SYNC(NB_SYNC)) u_sync (
            .clk     (clk),
            .i_rst   (i_rst),
            .i_async (i_btn[g]),
            .o_rise  (rise[g])
        );
    end

    assign pulse = rise & {3{i_valid}};

    // Next state: only the button expected by the current state counts
    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        unique case (state_q)
            S_WAIT_A, S_SHOW: if (pulse[0]) begin
                ld_a    = 1'b1;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: if (pulse[1]) begin
                ld_b    = 1'b1;
                state_d = S_WAIT_OP;
            end
            S_WAIT_OP: if (pulse[2]) begin
                ld_op   = 1'b1;
                state_d = S_SHOW;
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    assign alu_op = ld_op ? i_sw_data[NB_OP-1:0] : op_q;
    assign sra_v  = $signed(a_q) >>> b_q;

    // ALU on the held operands and the incoming op code
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (alu_op)
            C_ADD: begin
                {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
                alu_v = (a_q[M] == b_q[M]) && (alu_res[M] != a_q[M]);
            end
            C_SUB: begin
                {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q};
                alu_v = (a_q[M] != b_q[M]) && (alu_res[M] != a_q[M]);
            end
            C_AND: alu_res = a_q & b_q;
            C_OR:  alu_res = a_q | b_q;
            C_XOR: alu_res = a_q ^ b_q;
            C_NOR: alu_res = ~(a_q | b_q);
            C_SRL: begin
                if (b_q >= SH_LIM) alu_res = '0;
                else               alu_res = a_q >> b_q;
            end
            C_SRA: begin
                if (b_q >= SH_LIM) alu_res = {NB_DATA{a_q[M]}};
                else               alu_res = sra_v;
            end
            default: alu_err = 1'b1;
        endcase
        flags_d             = '0;
        flags_d[FLAG_ZERO]  = (alu_res == '0);
        flags_d[FLAG_CARRY] = alu_c;
        flags_d[FLAG_NEG]   = alu_res[M];
        flags_d[FLAG_OVF]   = alu_v;
    end

    // State, operand and result registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_WAIT_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_a) a_q <= i_sw_data;
            if (ld_b) b_q <= i_sw_data;
            if (ld_op) begin
                op_q     <= i_sw_data[NB_OP-1:0];
                result_q <= alu_res;
                flags_q  <= flags_d;
                err_q    <= alu_err;
            end
        end
    end

    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_state  = state_q;
    assign o_done   = (state_q == S_SHOW);
    assign o_err    = err_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench for alu_input_sequencer.
// Expected results are queued at OP press and popped on o_done.
module tb_alu_input_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int NB_SYNC = 2;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [2:0] i_btn;
    logic [7:0] i_sw_data;
    logic       i_valid;
    logic [7:0] o_result;
    logic [3:0] o_flags;
    logic [1:0] o_state;
    logic       o_done;
    logic       o_err;

    exp_t       sb[$];
    exp_t       last_exp;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] cur_a, cur_b;

    always #5 clk = ~clk;

    alu_input_sequencer #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP),
        .NB_SYNC (NB_SYNC)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_btn     (i_btn),
        .i_sw_data (i_sw_data),
        .i_valid   (i_valid),
        .o_result  (o_result),
        .o_flags   (o_flags),
        .o_state   (o_state),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    function automatic exp_t model(logic [7:0] a, logic [7:0] b,
                                   logic [5:0] op);
        exp_t e;
        int ua, ub, sa, sb2, r, s;
        logic [7:0] rv;
        logic c, v, known;
        ua = int'(a);
        ub = int'(b);
        sa = a[7] ? ua - 256 : ua;
        sb2 = b[7] ? ub - 256 : ub;
        c = 1'b0; v = 1'b0; known = 1'b1; r = 0; s = 0;
        case (op)
            ADD: begin
                r = ua + ub; c = (r > 255);
                s = sa + sb2; v = (s > 127) || (s < -128);
            end
            SUB: begin
                r = ua - ub; c = (ua < ub);
                s = sa - sb2; v = (s > 127) || (s < -128);
            end
            AND:         r = ua & ub;
            OR:          r = ua | ub;
            6'b100110:   r = ua ^ ub;
            6'b100111:   r = ~(ua | ub);
            SRL:         r = (ub >= 8) ? 0 : (ua >> ub);
            SRA:         r = sa >>> ((ub > 7) ? 7 : ub);
            default:     known = 1'b0;
        endcase
        rv = r[7:0];
        if (!known) begin
            e.res = 8'h00; e.flags = 4'b0001; e.err = 1'b1;
        end else begin
            e.res = rv;
            e.flags = {v, rv[7], c, (rv == 8'h00)};
            e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic press(input int idx, input logic [7:0] d);
        @(negedge clk);
        i_sw_data = d;
        i_btn[idx] = 1'b1;
        repeat (4) @(negedge clk);
        i_btn[idx] = 1'b0;
        repeat (NB_SYNC + 2) @(negedge clk);
    endtask

    task automatic load_a(input logic [7:0] d);
        press(0, d);
        cur_a = d;
    endtask

    task automatic load_b(input logic [7:0] d);
        press(1, d);
        cur_b = d;
    endtask

    task automatic do_op(input logic [5:0] op, input string nm);
        exp_t e;
        int n;
        sb.push_back(model(cur_a, cur_b, op));
        @(negedge clk);
        i_sw_data = {2'b00, op};
        i_btn[2] = 1'b1;
        n = 0;
        while (!o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== NB_SYNC + 1) begin
            fails++;
            $display("FAIL %s_latency got %0d want %0d", nm, n, NB_SYNC + 1);
        end
        e = sb.pop_front();
        last_exp = e;
        tests++;
        if ({o_result, o_flags} !== {e.res, e.flags}) begin
            fails++;
            $display("FAIL %s_result got %h/%b want %h/%b",
                     nm, o_result, o_flags, e.res, e.flags);
        end
        tests++;
        if (o_err !== e.err) begin
            fails++;
            $display("FAIL %s_err got %b want %b", nm, o_err, e.err);
        end
        i_btn[2] = 1'b0;
        repeat (NB_SYNC + 2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_btn = 3'b000;
        i_sw_data = 8'h00;
        i_valid = 1'b1;
        cur_a = 8'h00;
        cur_b = 8'h00;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({o_result, o_flags, o_state, o_done, o_err} !== 16'h0) begin
            fails++;
            $display("FAIL reset got %h/%b/%0d/%b/%b want 0",
                     o_result, o_flags, o_state, o_done, o_err);
        end
    endtask

    task automatic test_add();
        load_a(8'h7F);
        load_b(8'h01);
        do_op(ADD, "add_ovf");
        tests++;
        if ({o_result, o_flags, o_done} !== {8'h80, 4'b1100, 1'b1}) begin
            fails++;
            $display("FAIL add_const got %h/%b/%b want 80/1100/1",
                     o_result, o_flags, o_done);
        end
    endtask

    task automatic test_sub();
        load_a(8'h05);
        load_b(8'h05);
        do_op(SUB, "sub_zero");
        load_a(8'h03);
        load_b(8'h05);
        do_op(SUB, "sub_borrow");
        tests++;
        if ({o_result, o_flags} !== {8'hFE, 4'b0110}) begin
            fails++;
            $display("FAIL sub_const got %h/%b want fe/0110", o_result, o_flags);
        end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        cur_a = 8'h00;
        cur_b = 8'h00;
        press(2, 8'h25);
        press(1, 8'hAA);
        tests++;
        if (o_state !== 2'd0) begin
            fails++;
            $display("FAIL ooo_state got %0d want 0", o_state);
        end
        @(negedge clk);
        i_sw_data = 8'h11;
        i_btn[0] = 1'b1;
        repeat (50) @(negedge clk);
        i_btn[0] = 1'b0;
        cur_a = 8'h11;
        repeat (NB_SYNC + 2) @(negedge clk);
        tests++;
        if (o_state !== 2'd1) begin
            fails++;
            $display("FAIL hold_state got %0d want 1", o_state);
        end
        load_b(8'h22);
        do_op(ADD, "ooo_add");
        // btn0 held through a whole sequence must not reload A
        @(negedge clk);
        i_sw_data = 8'h0C;
        i_btn[0] = 1'b1;
        cur_a = 8'h0C;
        repeat (5) @(negedge clk);
        load_b(8'h03);
        do_op(OR, "held_or");
        repeat (10) @(negedge clk);
        tests++;
        if (o_state !== 2'd3) begin
            fails++;
            $display("FAIL held_retrig got %0d want 3", o_state);
        end
        i_btn[0] = 1'b0;
        repeat (NB_SYNC + 2) @(negedge clk);
    endtask

    task automatic test_shift();
        load_a(8'h90);
        load_b(8'd9);
        do_op(SRA, "sra_big");
        load_a(8'h90);
        load_b(8'd9);
        do_op(SRL, "srl_big");
        load_a(8'h90);
        load_b(8'd2);
        do_op(SRA, "sra_2");
        tests++;
        if (o_result !== 8'hE4) begin
            fails++;
            $display("FAIL sra_const got %h want e4", o_result);
        end
    endtask

    task automatic test_unsupported();
        load_a(8'h12);
        load_b(8'h34);
        do_op(6'b111111, "bad_op");
        tests++;
        if ({o_err, o_flags} !== 5'b1_0001) begin
            fails++;
            $display("FAIL bad_const got %b/%b want 1/0001", o_err, o_flags);
        end
        load_a(8'hF0);
        load_b(8'h3C);
        do_op(AND, "and_clr");
    endtask

    task automatic test_valid_reset();
        load_a(8'h40);
        tests++;
        if ({o_state, o_result} !== {2'd1, last_exp.res}) begin
            fails++;
            $display("FAIL hold_res got %0d/%h want 1/%h",
                     o_state, o_result, last_exp.res);
        end
        i_valid = 1'b0;
        press(1, 8'h55);
        @(negedge clk);
        i_btn[1] = 1'b1;
        repeat (5) @(negedge clk);
        i_valid = 1'b1;
        repeat (5) @(negedge clk);
        i_btn[1] = 1'b0;
        repeat (NB_SYNC + 2) @(negedge clk);
        tests++;
        if (o_state !== 2'd1) begin
            fails++;
            $display("FAIL valid_gate got %0d want 1", o_state);
        end
        load_b(8'h01);
        tests++;
        if (o_state !== 2'd2) begin
            fails++;
            $display("FAIL wait_op got %0d want 2", o_state);
        end
        @(negedge clk);
        i_rst = 1'b1;
        #1;
        tests++;
        if ({o_result, o_flags, o_state, o_done, o_err} !== 16'h0) begin
            fails++;
            $display("FAIL async_rst got %h/%b/%0d/%b/%b want 0",
                     o_result, o_flags, o_state, o_done, o_err);
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        cur_a = 8'h00;
        cur_b = 8'h00;
        repeat (2) @(negedge clk);
        load_a(8'hFF);
        load_b(8'h01);
        do_op(ADD, "add_carry");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_out_of_order();
        test_shift();
        test_unsupported();
        test_valid_reset();
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL sb_empty got %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
